// File: rtl/rtc_pkg.sv
// rtc_pkg: sequencer FSM states, RTC register address map and BCD helper
package rtc_pkg;
  typedef enum logic [2:0] {IDLE, ADDR_PH, GAP1, DATA_PH, STORE, GAP2} state_e;
  localparam logic [7:0] RTC_REG_MAP [0:8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                               8'h41, 8'h42, 8'h43};
  function automatic logic [7:0] reg_map(input logic [7:0] i);
    return (i < 8'd9) ? RTC_REG_MAP[i[3:0]] : 8'h00;
  endfunction
  function automatic logic bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction
endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: loadable down-counter; phase_end while the count is zero
module rtc_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         phase_end
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (load) cnt_q <= load_val;
    else if (cnt_q != '0) cnt_q <= cnt_q - W'(1);
  assign phase_end = cnt_q == '0;
endmodule

// File: rtl/rtc_read_sequencer.sv
// rtc_read_sequencer: scans RTC registers over the A/D bus into the register file.
// Optional RTC_BCD_CHECK_EN suppresses writes of non-BCD bytes and flags bcd_err.
module rtc_read_sequencer
  import rtc_pkg::*;
#(
  parameter int NUM_REGS       = 9,
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int PHASE_CYCLES   = 4,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hold,
  input  logic [DATA_WIDTH-1:0] ad_in,
  output logic [DATA_WIDTH-1:0] ad_out,
  output logic                  ad_oe,
  output logic                  rtc_cs_n,
  output logic                  rtc_ad,
  output logic                  rtc_rd_n,
  output logic                  rtc_wr_n,
  output logic [ADDR_WIDTH-1:0] rf_address,
  output logic [DATA_WIDTH-1:0] rf_data,
  output logic                  rf_we,
  output logic                  busy,
  output logic                  scan_done,
  output logic                  bcd_err
);
  localparam int TW = $clog2(REFRESH_CYCLES);
  localparam int PW = $clog2(PHASE_CYCLES + 1);
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [TW-1:0] tmr_q;
  logic pend_q, pend_d, wrap, req, launch, capture, last, phase_end, byte_ok;
  logic [DATA_WIDTH-1:0] ad_out_q, data_q;
  logic oe_q, cs_n_q, ad_q, rd_n_q, wr_n_q, we_q, busy_q, done_q;
  assign wrap    = tmr_q == TW'(REFRESH_CYCLES - 1);
  assign req     = pend_q | start | wrap;
  assign launch  = state_q == IDLE && req && !hold;
  assign capture = state_q == DATA_PH && phase_end;
  assign last    = idx_q == ADDR_WIDTH'(NUM_REGS - 1);
  rtc_phase_timer #(.W(PW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_d != state_q),
    .load_val (PW'(PHASE_CYCLES - 1)),
    .phase_end(phase_end)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = req;
    case (state_q)
      IDLE:    if (launch) begin state_d = ADDR_PH; pend_d = 1'b0; end
      ADDR_PH: state_d = phase_end ? GAP1 : ADDR_PH;
      GAP1:    state_d = phase_end ? DATA_PH : GAP1;
      DATA_PH: state_d = phase_end ? STORE : DATA_PH;
      STORE:   state_d = GAP2;
      GAP2:    if (phase_end) begin
        state_d = last ? IDLE : ADDR_PH;
        idx_d   = last ? '0 : idx_q + ADDR_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // Bus outputs are decoded from the next state so they change together with the FSM
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      tmr_q    <= '0;
      ad_out_q <= '0;
      oe_q     <= 1'b0;
      cs_n_q   <= 1'b1;
      ad_q     <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      data_q   <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      tmr_q    <= wrap ? '0 : tmr_q + TW'(1);
      ad_out_q <= (state_d == ADDR_PH) ? DATA_WIDTH'(reg_map(8'(idx_d))) : '0;
      oe_q     <= state_d == ADDR_PH;
      cs_n_q   <= !(state_d == ADDR_PH || state_d == DATA_PH);
      ad_q     <= state_d != ADDR_PH;
      rd_n_q   <= state_d != DATA_PH;
      wr_n_q   <= state_d != ADDR_PH;
      if (capture) data_q <= ad_in;
      we_q     <= capture && byte_ok;
      busy_q   <= state_d != IDLE;
      done_q   <= state_q == GAP2 && phase_end && last;
    end
`ifdef RTC_BCD_CHECK_EN
  logic err_q;
  assign byte_ok = bcd_ok(8'(ad_in));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else if (launch) err_q <= 1'b0;
    else if (capture && !byte_ok) err_q <= 1'b1;
  assign bcd_err = err_q;
`else
  assign byte_ok = 1'b1;
  assign bcd_err = 1'b0;
`endif
  assign ad_out     = ad_out_q;
  assign ad_oe      = oe_q;
  assign rtc_cs_n   = cs_n_q;
  assign rtc_ad     = ad_q;
  assign rtc_rd_n   = rd_n_q;
  assign rtc_wr_n   = wr_n_q;
  assign rf_address = idx_q;
  assign rf_data    = data_q;
  assign rf_we      = we_q;
  assign busy       = busy_q;
  assign scan_done  = done_q;
endmodule

// File: tb/tb_rtc_read_sequencer.sv
// tb_rtc_read_sequencer: directed scenarios with P=2, REFRESH_CYCLES=200 and a latching RTC model
module tb_rtc_read_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hold = 1'b0;
  logic [7:0] ad_in, ad_out, rf_data, lat = 8'h00;
  logic [3:0] rf_address;
  logic ad_oe, rtc_cs_n, rtc_ad, rtc_rd_n, rtc_wr_n, rf_we, busy, scan_done, bcd_err;
  int total = 0, bad = 0, cyc = 0, bad_idx = -1;
  logic pb = 1'b0;
  logic [7:0] tb_map [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  typedef struct {int c; logic [3:0] a; logic [7:0] d;} wev_t;
  wev_t wq[$];
  int lq[$], dq[$];

  rtc_read_sequencer #(.NUM_REGS(9), .ADDR_WIDTH(4), .DATA_WIDTH(8), .PHASE_CYCLES(2),
                       .REFRESH_CYCLES(200)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .ad_in(ad_in), .ad_out(ad_out),
    .ad_oe(ad_oe), .rtc_cs_n(rtc_cs_n), .rtc_ad(rtc_ad), .rtc_rd_n(rtc_rd_n),
    .rtc_wr_n(rtc_wr_n), .rf_address(rf_address), .rf_data(rf_data), .rf_we(rf_we),
    .busy(busy), .scan_done(scan_done), .bcd_err(bcd_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;
  // RTC model: latches the address on the write strobe, answers 8'h10+index
  always @(posedge clk) if (!rtc_wr_n && ad_oe) lat <= ad_out;
  always_comb begin
    ad_in = 8'hFF;
    for (int k = 0; k < 9; k++)
      if (lat == tb_map[k]) ad_in = (k == bad_idx) ? 8'h3A : 8'h10 + 8'(k);
  end
  always @(negedge clk) begin
    if (!rst_n) pb = 1'b0;
    else begin
      if (rf_we) wq.push_back('{cyc, rf_address, rf_data});
      if (scan_done) dq.push_back(cyc);
      if (busy && !pb) lq.push_back(cyc);
      pb = busy;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic pulse_start(input int n);
    wait_cyc(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic clear_logs();
    wq.delete();
    lq.delete();
    dq.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({ad_out, ad_oe, rtc_cs_n, rtc_ad, rtc_rd_n, rtc_wr_n, rf_address, rf_data, rf_we, busy,
         scan_done, bcd_err} !== {8'h00, 1'b0, 4'b1111, 4'h0, 8'h00, 4'b0000}) begin
      bad++;
      $display("FAIL reset_outputs got oe=%b cs=%b ad=%b rd=%b wr=%b addr=%h data=%h we=%b busy=%b",
               ad_oe, rtc_cs_n, rtc_ad, rtc_rd_n, rtc_wr_n, rf_address, rf_data, rf_we, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    pulse_start(5);
    wait_cyc(95);
    total++;
    if (lq.size() != 1 || lq[0] != 6) begin
      bad++;
      $display("FAIL scan_launch got n=%0d first=%0d exp 6", lq.size(), lq.size() ? lq[0] : -1);
    end
    total++;
    if (wq.size() != 9) begin bad++; $display("FAIL scan_count got %0d exp 9", wq.size()); end
    for (int i = 0; i < wq.size() && i < 9; i++) begin
      total++;
      if (wq[i].a !== 4'(i) || wq[i].d !== 8'h10 + 8'(i) || wq[i].c != 12 + 9 * i) begin
        bad++;
        $display("FAIL scan_write%0d got a=%h d=%h c=%0d exp a=%h d=%h c=%0d", i, wq[i].a,
                 wq[i].d, wq[i].c, 4'(i), 8'h10 + 8'(i), 12 + 9 * i);
      end
    end
    total++;
    if (dq.size() != 1 || dq[0] != 87) begin
      bad++;
      $display("FAIL scan_done got n=%0d c=%0d exp 87", dq.size(), dq.size() ? dq[0] : -1);
    end
  endtask

  task automatic test_bus();
    logic [4:0] exp_v;
    int off;
    pulse_start(100);
    for (int k = 0; k < 81; k++) begin
      off = k % 9;
      exp_v = {!(off < 2 || off == 4 || off == 5), !(off < 2), !(off == 4 || off == 5), off < 2,
               off == 6};
      total++;
      if ({rtc_cs_n, rtc_wr_n, rtc_rd_n, ad_oe, rf_we} !== exp_v) begin
        bad++;
        $display("FAIL bus_ctrl k=%0d got cs/wr/rd/oe/we=%b exp %b", k,
                 {rtc_cs_n, rtc_wr_n, rtc_rd_n, ad_oe, rf_we}, exp_v);
      end
      if (off < 2) begin
        total++;
        if (ad_out !== tb_map[k / 9] || rtc_ad !== 1'b0) begin
          bad++;
          $display("FAIL bus_addr k=%0d got ad_out=%h rtc_ad=%b exp %h 0", k, ad_out, rtc_ad,
                   tb_map[k / 9]);
        end
      end
      if (off == 4 || off == 5) begin
        total++;
        if (rtc_ad !== 1'b1) begin bad++; $display("FAIL bus_data k=%0d got rtc_ad=%b exp 1", k, rtc_ad); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_refresh();
    wait_cyc(190);
    clear_logs();
    pulse_start(220);
    pulse_start(230);
    wait_cyc(420);
    total++;
    if (lq.size() != 3 || lq[0] != 200 || lq[1] != 282 || lq[2] != 400) begin
      bad++;
      $display("FAIL refresh_launch got n=%0d %0d %0d %0d exp 200 282 400", lq.size(),
               lq.size() > 0 ? lq[0] : -1, lq.size() > 1 ? lq[1] : -1, lq.size() > 2 ? lq[2] : -1);
    end
    total++;
    if (dq.size() != 2 || dq[0] != 281 || dq[1] != 363) begin
      bad++;
      $display("FAIL refresh_done got n=%0d exp 281 363", dq.size());
    end
  endtask

  task automatic test_hold();
    wait_cyc(490);
    clear_logs();
    wait_cyc(500);
    hold = 1'b1;
    wait_cyc(650);
    total++;
    if (lq.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_block got launches=%0d busy=%b exp 0 0", lq.size(), busy);
    end
    hold = 1'b0;
    wait_cyc(660);
    total++;
    if (lq.size() != 1 || lq[0] != 651) begin
      bad++;
      $display("FAIL hold_release got n=%0d c=%0d exp 651", lq.size(), lq.size() ? lq[0] : -1);
    end
    wait_cyc(740);
  endtask

  task automatic test_abort();
    clear_logs();
    pulse_start(750);
    wait_cyc(791);
    total++;
    if ({rtc_cs_n, rtc_rd_n, rtc_ad} !== 3'b001 || wq.size() != 4) begin
      bad++;
      $display("FAIL abort_pre got cs/rd/ad=%b writes=%0d exp 001 4",
               {rtc_cs_n, rtc_rd_n, rtc_ad}, wq.size());
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({rtc_cs_n, rtc_rd_n, rtc_wr_n, ad_oe, rf_we, busy} !== 6'b111000) begin
      bad++;
      $display("FAIL abort_release got cs/rd/wr/oe/we/busy=%b exp 111000",
               {rtc_cs_n, rtc_rd_n, rtc_wr_n, ad_oe, rf_we, busy});
    end
    repeat (3) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    pulse_start(5);
    wait_cyc(95);
    total++;
    if (wq.size() != 9 || wq[0].a !== 4'h0 || wq[0].d !== 8'h10 || wq[0].c != 12) begin
      bad++;
      $display("FAIL abort_restart got n=%0d a=%h d=%h c=%0d exp 9 0 10 12", wq.size(),
               wq.size() ? wq[0].a : 4'hx, wq.size() ? wq[0].d : 8'hxx, wq.size() ? wq[0].c : -1);
    end
  endtask

  task automatic test_bcd();
    wev_t eq[$];
    clear_logs();
    bad_idx = 2;
    for (int a = 0; a < 9; a++) begin
`ifdef RTC_BCD_CHECK_EN
      if (a != 2) eq.push_back('{107 + 9 * a, 4'(a), 8'h10 + 8'(a)});
`else
      eq.push_back('{107 + 9 * a, 4'(a), (a == 2) ? 8'h3A : 8'h10 + 8'(a)});
`endif
    end
    pulse_start(100);
    wait_cyc(190);
    bad_idx = -1;
    total++;
    if (wq.size() != eq.size()) begin
      bad++;
      $display("FAIL bcd_count got %0d exp %0d", wq.size(), eq.size());
    end
    for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
      total++;
      if (wq[i].a !== eq[i].a || wq[i].d !== eq[i].d || wq[i].c != eq[i].c) begin
        bad++;
        $display("FAIL bcd_write%0d got a=%h d=%h c=%0d exp a=%h d=%h c=%0d", i, wq[i].a,
                 wq[i].d, wq[i].c, eq[i].a, eq[i].d, eq[i].c);
      end
    end
    total++;
`ifdef RTC_BCD_CHECK_EN
    if (bcd_err !== 1'b1) begin bad++; $display("FAIL bcd_flag got %b exp 1", bcd_err); end
`else
    if (bcd_err !== 1'b0) begin bad++; $display("FAIL bcd_flag got %b exp 0", bcd_err); end
`endif
    wait_cyc(200);
    total++;
    if (busy !== 1'b1 || bcd_err !== 1'b0) begin
      bad++;
      $display("FAIL bcd_clear got busy=%b bcd_err=%b exp 1 0", busy, bcd_err);
    end
    wait_cyc(290);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_bus();
    test_refresh();
    test_hold();
    test_abort();
    test_bcd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
